// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one multi-cycle single-port memory between instruction fetch (IF)
//   and data access (MEM). Data is served first, then the fetch; results are
//   latched and the whole pipeline is stalled until every access requested in
//   the current pipeline cycle has completed (or timed out).
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   if_req_i/if_addr_i      fetch request and PC
//   if_instr_o              latched fetched instruction
//   dm_read_i/dm_write_i    MEM-stage load/store (both high = store)
//   dm_addr_i/dm_wdata_i    data address / store data
//   dm_rdata_o              latched load data
//   stall_o                 combinational pipeline-wide freeze
//   mem_req_o/we/addr/wdata registered memory request
//   mem_ack_i/mem_rdata_i   memory completion, rdata valid with ack
//   err_o                   sticky timeout flag
module unified_mem_arbiter #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] NOP_INSTR = 'h00000013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_instr_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT} state_t;

  // Counter holds the number of wait cycles already spent without an ack,
  // so the access is abandoned at the end of the TIMEOUT-th wait cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic              r_d_served, w_d_served_nxt;
  logic              r_i_served, w_i_served_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_req, w_req_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_instr, w_instr_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_err, w_err_nxt;

  logic w_d_need, w_i_need, w_stall;

  assign w_d_need = (dm_read_i | dm_write_i) & ~r_d_served;
  assign w_i_need = if_req_i & ~r_i_served;
  assign w_stall  = w_d_need | w_i_need | (r_state != IDLE);

  always_comb begin
    w_state_nxt    = r_state;
    w_d_served_nxt = r_d_served;
    w_i_served_nxt = r_i_served;
    w_cnt_nxt      = r_cnt;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_instr_nxt    = r_instr;
    w_rdata_nxt    = r_rdata;
    w_err_nxt      = r_err;

    case (r_state)
      IDLE: begin
        // Pipeline advances on this edge: start a fresh pipeline cycle.
        if (!w_stall) begin
          w_d_served_nxt = 1'b0;
          w_i_served_nxt = 1'b0;
        end
        if (w_d_need) begin
          w_addr_nxt  = dm_addr_i;
          w_wdata_nxt = dm_wdata_i;
          w_we_nxt    = dm_write_i;  // read+write together is a write
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = D_WAIT;
        end else if (w_i_need) begin
          w_addr_nxt  = if_addr_i;
          w_we_nxt    = 1'b0;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = I_WAIT;
        end
      end

      D_WAIT, I_WAIT: begin
        if (mem_ack_i) begin
          if (r_state == I_WAIT) begin
            w_instr_nxt    = mem_rdata_i;
            w_i_served_nxt = 1'b1;
          end else begin
            if (!r_we) w_rdata_nxt = mem_rdata_i;
            w_d_served_nxt = 1'b1;
          end
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          // Abandon the access: substitute a NOP / zero data and carry on.
          if (r_state == I_WAIT) begin
            w_instr_nxt    = NOP_INSTR;
            w_i_served_nxt = 1'b1;
          end else begin
            if (!r_we) w_rdata_nxt = '0;
            w_d_served_nxt = 1'b1;
          end
          w_err_nxt   = 1'b1;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_d_served <= 1'b0;
      r_i_served <= 1'b0;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_instr    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_d_served <= w_d_served_nxt;
      r_i_served <= w_i_served_nxt;
      r_cnt      <= w_cnt_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_instr    <= w_instr_nxt;
      r_rdata    <= w_rdata_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign stall_o     = w_stall;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign if_instr_o  = r_instr;
  assign dm_rdata_o  = r_rdata;
  assign err_o       = r_err;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected memory issues and expected
// pipeline-advance results; the monitor pops and compares them when the DUT
// raises mem_req_o or releases stall_o.
module tb_unified_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_instr_o;
  logic        dm_read_i = 1'b0;
  logic        dm_write_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [31:0] dm_rdata_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  unified_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_instr_o(if_instr_o),
    .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_adv;  // 0: memory issue, 1: pipeline advance
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] instr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rd_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  // memory responder
  bit          mem_en = 1'b0;
  int          ack_delay = 0;
  logic        resp_ack = 1'b0;
  logic        late_ack = 1'b0;
  logic [31:0] resp_data = '0;
  assign mem_ack_i   = resp_ack | late_ack;
  assign mem_rdata_i = resp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic exp_t mk_issue(logic [31:0] a, logic w, logic [31:0] d);
    exp_t e;
    e = '{is_adv: 1'b0, addr: a, we: w, wdata: d, stalls: 0, instr: '0, rdata: '0, err: 1'b0};
    return e;
  endfunction

  function automatic exp_t mk_adv(int s, logic [31:0] ins, logic [31:0] rd, logic er);
    exp_t e;
    e = '{is_adv: 1'b1, addr: '0, we: 1'b0, wdata: '0, stalls: s, instr: ins, rdata: rd, err: er};
    return e;
  endfunction

  // Responder: acks ack_delay cycles into the wait, acting just after posedge.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk_i); #1;
      resp_ack = 1'b0;
      if (mem_en && mem_req_o === 1'b1) begin
        if (wcnt == ack_delay) begin
          resp_ack  = 1'b1;
          resp_data = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    logic prev_req;
    int   scnt;
    exp_t e;
    prev_req = 1'b0;
    scnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i || scnt > 0) begin
        if (mem_req_o === 1'b1 && prev_req !== 1'b1) begin
          if (sb.size() == 0) check("unexpected_issue", mem_addr_o, 32'hFFFFFFFF);
          else begin
            e = sb.pop_front();
            check("issue_kind", {31'd0, e.is_adv}, 32'd0);
            check("issue_addr", mem_addr_o, e.addr);
            check("issue_we", {31'd0, mem_we_o}, {31'd0, e.we});
            if (e.we) check("issue_wdata", mem_wdata_o, e.wdata);
          end
        end
        if (stall_o === 1'b1) scnt++;
        else if (scnt > 0) begin
          if (sb.size() == 0) check("unexpected_advance", 32'(scnt), 32'hFFFFFFFF);
          else begin
            e = sb.pop_front();
            check("adv_kind", {31'd0, e.is_adv}, 32'd1);
            check("stall_cycles", 32'(scnt), 32'(e.stalls));
            check("if_instr", if_instr_o, e.instr);
            check("dm_rdata", dm_rdata_o, e.rdata);
            check("err", {31'd0, err_o}, {31'd0, e.err});
          end
          scnt = 0;
        end
      end
      prev_req = mem_req_o;
    end
  end

  // One pipeline cycle: drive requests, hold until stall releases, then clear.
  task automatic pcycle(input logic ireq, input logic [31:0] ia, input logic rd,
                        input logic wr, input logic [31:0] da, input logic [31:0] wd);
    int n;
    @(posedge clk_i); #1;
    if_req_i = ireq; if_addr_i = ia;
    dm_read_i = rd; dm_write_i = wr; dm_addr_i = da; dm_wdata_i = wd;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (stall_o !== 1'b0 && n < 400);
    if (n >= 400) check("advance_timeout", 32'(n), 32'd0);
    @(posedge clk_i); #1;
    if_req_i = 1'b0; dm_read_i = 1'b0; dm_write_i = 1'b0;
  endtask

  initial begin
    // reset and idle
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("idle_stall", {31'd0, stall_o}, 32'd0);
      check("idle_req", {31'd0, mem_req_o}, 32'd0);
      check("idle_instr", if_instr_o, 32'd0);
      check("idle_err", {31'd0, err_o}, 32'd0);
    end
    mem_en = 1'b1;

    // single fetch, zero-wait memory
    ack_delay = 0;
    rd_q.push_back(32'h00A00093);
    sb.push_back(mk_issue(32'h40, 1'b0, 32'h0));
    sb.push_back(mk_adv(2, 32'h00A00093, 32'h0, 1'b0));
    pcycle(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);

    // fetch + load together: data first
    rd_q.push_back(32'hDEADBEEF);
    rd_q.push_back(32'h00000013);
    sb.push_back(mk_issue(32'h100, 1'b0, 32'h0));
    sb.push_back(mk_issue(32'h44, 1'b0, 32'h0));
    sb.push_back(mk_adv(4, 32'h00000013, 32'hDEADBEEF, 1'b0));
    pcycle(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0);

    // store with 5 extra wait cycles; load data must not change
    ack_delay = 5;
    rd_q.push_back(32'hFFFFFFFF);
    sb.push_back(mk_issue(32'h200, 1'b1, 32'h12345678));
    sb.push_back(mk_adv(7, 32'h00000013, 32'hDEADBEEF, 1'b0));
    pcycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h12345678);

    // read+write together is a write, then the fetch
    ack_delay = 0;
    rd_q.push_back(32'h55555555);
    rd_q.push_back(32'hAAAA0001);
    sb.push_back(mk_issue(32'h204, 1'b1, 32'hCAFEF00D));
    sb.push_back(mk_issue(32'h48, 1'b0, 32'h0));
    sb.push_back(mk_adv(4, 32'hAAAA0001, 32'hDEADBEEF, 1'b0));
    pcycle(1'b1, 32'h48, 1'b1, 1'b1, 32'h204, 32'hCAFEF00D);

    // fetch timeout: 255 wait cycles, NOP substituted, err sticky
    mem_en = 1'b0;
    sb.push_back(mk_issue(32'h80, 1'b0, 32'h0));
    sb.push_back(mk_adv(256, 32'h00000013, 32'hDEADBEEF, 1'b1));
    pcycle(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);

    // late ack in IDLE is ignored
    resp_data = 32'h77777777;
    late_ack = 1'b1;
    @(posedge clk_i); #1 late_ack = 1'b0;
    @(negedge clk_i);
    check("late_ack_instr", if_instr_o, 32'h00000013);
    check("late_ack_req", {31'd0, mem_req_o}, 32'd0);
    check("late_ack_stall", {31'd0, stall_o}, 32'd0);

    // reset while in D_WAIT abandons the load and clears everything
    @(posedge clk_i); #1;
    dm_read_i = 1'b1; dm_addr_i = 32'h300;
    sb.push_back(mk_issue(32'h300, 1'b0, 32'h0));
    sb.push_back(mk_adv(2, 32'h0, 32'h0, 1'b0));
    @(posedge clk_i); #1;
    rst_i = 1'b1; dm_read_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk_i); #1 late_ack = 1'b1;
    @(posedge clk_i); #1 late_ack = 1'b0;
    @(negedge clk_i);
    check("rst_late_ack_rdata", dm_rdata_o, 32'd0);
    check("rst_late_ack_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_late_ack_stall", {31'd0, stall_o}, 32'd0);

    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Schedules the 5-stage pipeline's instruction fetch (IF) and data access (MEM) onto one shared, multi-cycle, single-port memory through a req/ack handshake.
- Serializes the two requesters, with data given priority, and latches the results.
- Drives a single pipeline-wide stall so that all pipeline registers and the PC advance only once every access of the current pipeline cycle has completed.
- Sits between the PC/IF/ID and EX/MEM pipeline registers and the memory wrapper.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles spent waiting for mem_ack_i before the access is abandoned (8-bit counter)
NOP_INSTR, 32'h00000013, instruction returned on a fetch timeout (addi x0,x0,0)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
if_req_i  in  1  IF requests an instruction fetch this pipeline cycle
if_addr_i  in  ADDR_W  fetch address (PC)
if_instr_o  out  DATA_W  latched fetched instruction
dm_read_i  in  1  MEM-stage load
dm_write_i  in  1  MEM-stage store
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  store data
dm_rdata_o  out  DATA_W  latched load data
stall_o  out  1  combinational; freezes PC and all pipeline registers while high
mem_req_o  out  1  registered memory request
mem_we_o  out  1  registered write enable
mem_addr_o  out  ADDR_W  registered address
mem_wdata_o  out  DATA_W  registered write data
mem_ack_i  in  1  memory completion; read data is valid in the same cycle
mem_rdata_i  in  DATA_W  memory read data
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (clk_i edge with rst_i=1):
  - state=IDLE; d_served=0, i_served=0; wait counter=0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o = 0.
  - if_instr_o=0, dm_rdata_o=0, err_o=0.
  - Reset mid-transaction abandons the access; mem_req_o is 0 on the following cycle.
- Need terms:
  - d_need = (dm_read_i | dm_write_i) & ~d_served
  - i_need = if_req_i & ~i_served
- Stall: stall_o = d_need | i_need | (state != IDLE).
- Pipeline advance: a clock edge with stall_o=0. On that edge d_served and i_served are cleared.
- Input stability: requester inputs must remain stable while stall_o=1. The arbiter samples address and data only at issue.
- States:
  - IDLE:
    - If d_need: register mem_addr_o=dm_addr_i, mem_wdata_o=dm_wdata_i, mem_we_o=dm_write_i, mem_req_o=1; go to D_WAIT.
    - Else if i_need: register mem_addr_o=if_addr_i, mem_we_o=0, mem_req_o=1; go to I_WAIT.
    - Else remain in IDLE.
    - Data always wins over instruction.
  - D_WAIT / I_WAIT:
    - Hold all mem_* outputs; the counter increments each cycle.
    - On mem_ack_i=1:
      - D_WAIT with a read: dm_rdata_o<=mem_rdata_i. A write leaves dm_rdata_o unchanged.
      - I_WAIT: if_instr_o<=mem_rdata_i.
      - Set the corresponding served flag, mem_req_o<=0, mem_we_o<=0, counter<=0, go to IDLE.
    - On counter reaching TIMEOUT with no ack:
      - Set err_o=1 (cleared only by reset) and mark the access served.
      - I_WAIT: if_instr_o<=NOP_INSTR. D_WAIT read: dm_rdata_o<=0.
      - Drop mem_req_o and return to IDLE.
- Ignored inputs: mem_ack_i is ignored in IDLE, including a late ack after a timeout or reset.
- Latency with zero-wait memory (ack in the first WAIT cycle):
  - Single access: 2 stalled cycles, advance on the 3rd.
  - Both accesses: 4 stalled cycles (IDLE, D_WAIT, IDLE, I_WAIT), advance on the 5th.
- Read and write together: dm_read_i and dm_write_i both high is treated as a write.
- No requests: stall_o=0 and the pipeline advances every cycle.
- Ordering: at most one outstanding memory transaction; no re-issue of a served access within the same pipeline cycle.

Test Plan:
- Reset then idle inputs -> stall_o=0, mem_req_o=0, if_instr_o=0, err_o=0 every cycle.
- if_req_i=1, if_addr_i=0x40; ack 1 cycle after mem_req_o with rdata 0x00A00093 -> mem_addr_o=0x40, mem_we_o=0, stall_o high for 2 cycles, then if_instr_o=0x00A00093 and stall_o=0 for one cycle.
- Simultaneous if_req_i (0x44) and dm_read_i (0x100); memory returns 0xDEADBEEF then 0x00000013 -> first issue is addr 0x100, second is 0x44. dm_rdata_o=0xDEADBEEF, if_instr_o=0x00000013, stall_o high 4 cycles.
- dm_write_i=1, addr 0x200, wdata 0x12345678 -> mem_we_o=1 with those values; dm_rdata_o unchanged; mem_ack_i delayed 5 cycles stretches the stall by 5.
- Fetch with no ack for 255 cycles -> err_o=1, if_instr_o=0x00000013, stall_o releases; a late ack in IDLE causes no change.
- rst_i asserted during D_WAIT -> next cycle state IDLE, mem_req_o=0, flags cleared; a subsequent ack is ignored.
